// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the iterative RV-M multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   // Special-case divides resolve on the accept edge and never occupy a state.
   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return op[2] ? ~op[0] : (op != OP_MULHU);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return op[2] ? ~op[0] : ((op == OP_MUL) || (op == OP_MULH));
   endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_divstep #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_dvs,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);
   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   logic          w_ge;

   // Partial remainder stays below the divisor, so bit XLEN of the difference is the borrow.
   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, i_dvs};
   assign w_ge    = ~w_diff[XLEN];

   assign o_rem = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
   assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV-M multiply/divide unit with special-case fast path and DIV<->REM result reuse.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] in_A,
   input  logic [XLEN-1:0] in_B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] R
);
   localparam int                MUL_ITER = XLEN / MUL_STEP;
   localparam int                CW       = $clog2(XLEN);
   localparam logic [CW-1:0]     MUL_CNT0 = CW'(MUL_ITER - 2);
   localparam logic [CW-1:0]     DIV_CNT0 = CW'(XLEN - 2);
   localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [2:0]          r_op;
   logic [XLEN-1:0]     r_mag_a, r_mag_b;
   logic                r_neg_q, r_neg_r;
   logic [2*XLEN-1:0]   r_acc;
   logic                r_done;
   logic [XLEN-1:0]     r_res;

   logic                r_c_vld, r_c_sgn, r_c_rem;
   logic [XLEN-1:0]     r_c_a, r_c_b, r_c_q, r_c_r;

   logic                w_sa, w_sb, w_b_zero, w_ovf, w_hit, w_accept, w_fast;
   logic [XLEN-1:0]     w_mag_a, w_mag_b, w_fast_res, w_fix_res;
   logic [XLEN+MUL_STEP-1:0] w_pp, w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_acc, w_step_acc, w_prod;
   logic [XLEN-1:0]     w_div_rem, w_div_quo, w_quo, w_rem;

   assign w_sa    = is_signed_a(op) & in_A[XLEN-1];
   assign w_sb    = is_signed_b(op) & in_B[XLEN-1];
   assign w_mag_a = w_sa ? -in_A : in_A;
   assign w_mag_b = w_sb ? -in_B : in_B;

   assign w_b_zero = (in_B == '0);
   assign w_ovf    = ~op[0] & (in_A == MIN_INT) & (in_B == '1);
   assign w_hit    = r_c_vld & (in_A == r_c_a) & (in_B == r_c_b) &
                     (r_c_sgn == ~op[0]) & (r_c_rem != op[1]);

   // kill wins over a same-cycle start
   assign w_accept = (r_state == S_IDLE) & start & ~kill;
   assign w_fast   = w_accept & is_div(op) & (w_b_zero | w_ovf | w_hit);

   always_comb begin
      w_fast_res = '1;
      if (w_b_zero)   w_fast_res = op[1] ? in_A : '1;
      else if (w_ovf) w_fast_res = op[1] ? '0 : in_A;
      else            w_fast_res = op[1] ? r_c_r : r_c_q;
   end

   // Radix-2^MUL_STEP shift-add: multiplier sits in the low half and drains out to the right.
   always_comb begin
      w_pp = '0;
      for (int k = 0; k < MUL_STEP; k++)
         if (r_acc[k]) w_pp = w_pp + ({{MUL_STEP{1'b0}}, r_mag_a} << k);
      w_mul_sum = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
      w_mul_acc = {w_mul_sum, r_acc[XLEN-1:MUL_STEP]};
   end

   muldiv_divstep #(.XLEN(XLEN)) u_divstep (
      .i_rem (r_acc[2*XLEN-1:XLEN]),
      .i_quo (r_acc[XLEN-1:0]),
      .i_dvs (r_mag_b),
      .o_rem (w_div_rem),
      .o_quo (w_div_quo)
   );

   assign w_step_acc = is_div(r_op) ? {w_div_rem, w_div_quo} : w_mul_acc;

   // FIX performs the last iteration combinationally, then restores signs.
   assign w_prod = r_neg_q ? -w_step_acc : w_step_acc;
   assign w_quo  = r_neg_q ? -w_div_quo  : w_div_quo;
   assign w_rem  = r_neg_r ? -w_div_rem  : w_div_rem;

   always_comb begin
      case (r_op)
         OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix_res = w_quo;
         default:                      w_fix_res = w_rem;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (w_accept && !w_fast) w_state_nxt = is_div(op) ? S_DIV : S_MUL;
         S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:        w_state_nxt = S_IDLE;
         default:      w_state_nxt = S_IDLE;
      endcase
      if (kill) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_acc   <= '0;
         r_done  <= 1'b0;
         r_res   <= '0;
         r_c_vld <= 1'b0;
         r_c_sgn <= 1'b0;
         r_c_rem <= 1'b0;
         r_c_a   <= '0;
         r_c_b   <= '0;
         r_c_q   <= '0;
         r_c_r   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if (kill && r_state != S_IDLE) begin
            r_c_vld <= 1'b0;
         end else if (w_accept) begin
            r_op    <= op;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_acc   <= {{XLEN{1'b0}}, is_div(op) ? w_mag_a : w_mag_b};
            r_cnt   <= is_div(op) ? DIV_CNT0 : MUL_CNT0;
            if (w_fast) begin
               r_res  <= w_fast_res;
               r_done <= 1'b1;
               if (!w_hit) r_c_vld <= 1'b0;
            end else begin
               // operands recorded now; entry becomes valid only when the divide completes
               r_c_vld <= 1'b0;
               r_c_a   <= in_A;
               r_c_b   <= in_B;
               r_c_sgn <= ~op[0];
               r_c_rem <= op[1];
            end
         end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - CW'(1);
         end else if (r_state == S_FIX) begin
            r_res  <= w_fix_res;
            r_done <= 1'b1;
            if (is_div(r_op)) begin
               r_c_vld <= 1'b1;
               r_c_q   <= w_quo;
               r_c_r   <= w_rem;
            end
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign R    = r_res;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit at XLEN=32, MUL_STEP=2 (MUL latency 17, DIV latency 33).
module tb_muldiv_iter_unit;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] in_A = '0, in_B = '0;
   logic [31:0] R;
   logic        busy, done;
   int          n_chk = 0, n_err = 0;

   muldiv_iter_unit #(.XLEN(32), .MUL_STEP(2)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .kill  (kill),
      .op    (op),
      .in_A  (in_A),
      .in_B  (in_B),
      .busy  (busy),
      .done  (done),
      .R     (R)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Launch one op, wait (bounded) for done, check latency, result, busy profile, pulse width.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r_exp, input int lat_exp);
      int lat, nb;
      @(negedge clk);
      op = o; in_A = a; in_B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; nb = 0;
      while (!done && lat < 100) begin
         if (!busy) nb++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(lat_exp));
      chk({tag, ".res"}, R, r_exp);
      chk({tag, ".busy"}, 32'(nb) + {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      chk({tag, ".pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int lat, dn;
      #2;
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.done", {31'b0, done}, 32'd0);
      chk("rst.R", R, 32'd0);
      @(negedge clk); reset = 1'b1;

      // special cases, single cycle
      run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      run_op("rem_by0",  3'd6, 32'd5, 32'd0, 32'd5, 1);
      run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

      // high-half multiplies
      run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 17);
      run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17);
      run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17);

      // signed divide, reuse hit, signedness miss
      run_op("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      run_op("rem_hit", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1);
      run_op("remu_miss", 3'd7, 32'hFFFFFFF9, 32'd2, 32'd1, 33);

      run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 17);
      run_op("div_100_7", 3'd4, 32'd100, 32'd7, 32'd14, 33);

      // kill mid-divide: no done, R kept, reuse entry dropped
      @(negedge clk);
      op = 3'd4; in_A = 32'd100; in_B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill.busy", {31'b0, busy}, 32'd0);
      chk("kill.done", {31'b0, done}, 32'd0);
      chk("kill.R", R, 32'd14);
      dn = 0;
      repeat (40) begin @(posedge clk); #1; if (done) dn++; end
      chk("kill.nodone", 32'(dn), 32'd0);
      run_op("rem_after_kill", 3'd6, 32'd100, 32'd7, 32'd2, 33);

      // a multiply in between drops the reuse entry
      run_op("div_9_2", 3'd4, 32'd9, 32'd2, 32'd4, 33);
      run_op("mul_3_3", 3'd0, 32'd3, 32'd3, 32'd9, 17);
      run_op("rem_9_2", 3'd6, 32'd9, 32'd2, 32'd1, 33);

      // start with kill in idle: not accepted
      @(negedge clk);
      op = 3'd0; in_A = 32'd2; in_B = 32'd2; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      chk("startkill.busy", {31'b0, busy}, 32'd0);
      dn = 0;
      repeat (20) begin @(posedge clk); #1; if (done) dn++; end
      chk("startkill.nodone", 32'(dn), 32'd0);
      chk("startkill.R", R, 32'd1);

      // start held while busy with a new operand: ignored
      @(negedge clk);
      op = 3'd0; in_A = 32'd7; in_B = 32'hFFFFFFFD; start = 1'b1;
      @(posedge clk); #1;
      in_A = 32'd5;
      lat = 1;
      while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
      start = 1'b0;
      chk("hold.lat", 32'(lat), 32'd17);
      chk("hold.res", R, 32'hFFFFFFEB);
      @(posedge clk); #1;
      chk("hold.idle", {31'b0, busy}, 32'd0);

      // async reset mid-divide
      @(negedge clk);
      op = 3'd4; in_A = 32'd100; in_B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst.pre", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst.busy", {31'b0, busy}, 32'd0);
      chk("midrst.done", {31'b0, done}, 32'd0);
      chk("midrst.R", R, 32'd0);
      @(negedge clk); reset = 1'b1;
      run_op("post_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
